// File: rtl/mac_seq_if.sv
// mac_seq_if: host, datapath and result-stream signals of the MAC sequencer.
//   master: environment side (host, MAC datapath, result consumer)
//   slave : mac_seq_ctrl side
//   start/cfg_len          job request and operand-pair count
//   in_data/valid/ready    operand byte stream, A then B per pair
//   mac_a/b/en/clr/acc     datapath operands, strobes and accumulator
//   out_data/valid/ready   result byte stream, LSB first
//   busy/done/err          job status
interface mac_seq_if #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 5
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_acc;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             err;
    modport master (
        output start, cfg_len, in_data, in_valid, mac_acc, out_ready,
        input  in_ready, mac_a, mac_b, mac_en, mac_clr, out_data, out_valid, busy, done, err
    );
    modport slave (
        input  start, cfg_len, in_data, in_valid, mac_acc, out_ready,
        output in_ready, mac_a, mac_b, mac_en, mac_clr, out_data, out_valid, busy, done, err
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences clear/accumulate strobes for the MAC datapath and
// streams the accumulated result back as bytes, LSB first.
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active high despite the name
//   abort  only when MAC_SEQ_ABORT_EN is defined: drops any running job
//   bus    mac_seq_if.slave (host, datapath and result stream)
module mac_seq_ctrl #(
    parameter int ACC_W   = 20,
    parameter int LEN_W   = 5,
    parameter int MAC_LAT = 1
) (
    input logic clk,
    input logic rst_n,
`ifdef MAC_SEQ_ABORT_EN
    input logic abort,
`endif
    mac_seq_if.slave bus
);
    localparam int NB     = (ACC_W + 7) / 8;
    localparam int RES_W  = NB * 8;
    localparam int IDX_W  = NB > 1 ? $clog2(NB) : 1;
    localparam int WAIT_W = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, ISSUE, WAIT, OUT} state_t;
    state_t             r_state, w_next;
    logic [LEN_W-1:0]   r_len, r_cnt;
    logic [7:0]         r_a, r_b;
    logic [RES_W-1:0]   r_res;
    logic [IDX_W-1:0]   r_idx;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_err, r_done;
    logic               w_len_ok, w_abort, w_last_byte, w_wait_end;
    logic [RES_W-1:0]   w_shift;
    assign w_len_ok    = bus.cfg_len != '0 && 32'(bus.cfg_len) <= 32'd16;
`ifdef MAC_SEQ_ABORT_EN
    assign w_abort     = abort && r_state != IDLE;
`else
    assign w_abort     = 1'b0;
`endif
    assign w_last_byte = r_idx == IDX_W'(NB - 1);
    assign w_wait_end  = r_wait == WAIT_W'(MAC_LAT - 1);
    assign w_shift     = r_res >> {r_idx, 3'b000};
    always_comb begin
        w_next        = r_state;
        bus.busy      = r_state != IDLE;
        bus.mac_clr   = r_state == CLEAR && !w_abort;
        bus.mac_en    = r_state == ISSUE && !w_abort;
        bus.in_ready  = (r_state == LOAD_A || r_state == LOAD_B) && !w_abort;
        bus.out_valid = r_state == OUT && !w_abort;
        bus.out_data  = bus.out_valid ? w_shift[7:0] : 8'h00;
        bus.mac_a     = r_a;
        bus.mac_b     = r_b;
        bus.err       = r_err;
        bus.done      = r_done;
        case (r_state)
            IDLE:    w_next = bus.start && w_len_ok ? CLEAR : IDLE;
            CLEAR:   w_next = LOAD_A;
            LOAD_A:  w_next = bus.in_valid ? LOAD_B : LOAD_A;
            LOAD_B:  w_next = bus.in_valid ? ISSUE : LOAD_B;
            ISSUE:   w_next = r_cnt + LEN_W'(1) == r_len ? WAIT : LOAD_A;
            WAIT:    w_next = w_wait_end ? OUT : WAIT;
            OUT:     w_next = bus.out_ready && w_last_byte ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_idx  <= '0;
            r_wait <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            // An abort is reported on err so the host can tell it from completion.
            r_err  <= (r_state == IDLE && bus.start && !w_len_ok) || w_abort;
            r_done <= bus.out_valid && bus.out_ready && w_last_byte;
            r_wait <= r_state == WAIT && !w_wait_end ? r_wait + WAIT_W'(1) : '0;
            if (r_state == IDLE && bus.start && w_len_ok) begin
                r_len <= bus.cfg_len;
                r_cnt <= '0;
            end
            if (bus.in_ready && bus.in_valid && r_state == LOAD_A) r_a <= bus.in_data;
            if (bus.in_ready && bus.in_valid && r_state == LOAD_B) r_b <= bus.in_data;
            if (bus.mac_en) r_cnt <= r_cnt + LEN_W'(1);
            if (r_state == WAIT && w_wait_end) r_res <= RES_W'(bus.mac_acc);
            if (w_abort) r_idx <= '0;
            else if (bus.out_valid && bus.out_ready) r_idx <= w_last_byte ? '0 : r_idx + IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl with a MAC_LAT=1 datapath model.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   n_en = 0, n_clr = 0, n_done = 0, n_err = 0, n_viol = 0;
    logic [7:0]  pa [16];
    logic [7:0]  pb [16];
    logic [19:0] acc;
    always #5 clk = ~clk;
    mac_seq_if #(.ACC_W(20), .LEN_W(5)) bus();
    mac_seq_ctrl #(.ACC_W(20), .LEN_W(5), .MAC_LAT(1)) dut (
        .clk(clk),
        .rst_n(rst),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );
    always @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (bus.mac_clr) acc <= '0;
        else if (bus.mac_en) acc <= acc + 20'(bus.mac_a) * 20'(bus.mac_b);
    end
    assign bus.mac_acc = acc;
    always @(posedge clk) begin
        if (bus.mac_en) begin
            pa[n_en[3:0]] = bus.mac_a;
            pb[n_en[3:0]] = bus.mac_b;
            n_en++;
        end
        if (bus.mac_clr) n_clr++;
        if (bus.done) n_done++;
        if (bus.err) n_err++;
        if (bus.in_ready && (bus.mac_en || bus.out_valid)) n_viol++;
    end
    task automatic start_job(input logic [4:0] len);
        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_len = len;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        bus.in_data = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    task automatic recv(input int stall, output logic [7:0] got, output logic held);
        int t = 0;
        logic [7:0] first;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        got = bus.out_valid ? bus.out_data : 8'hxx;
        first = bus.out_data;
        held = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== first) held = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    task automatic test_reset;
        #2;
        checks++;
        if ({bus.busy, bus.in_ready, bus.mac_en, bus.mac_clr, bus.out_valid, bus.done, bus.err, bus.mac_a, bus.mac_b, bus.out_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs busy=%b a=%h b=%h out=%h required all zero", bus.busy, bus.mac_a, bus.mac_b, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_basic;
        logic [7:0] got [3];
        logic [7:0] exp [3] = '{8'h27, 8'h00, 8'h00};
        logic held;
        int e0 = n_en, c0 = n_clr, d0 = n_done;
        logic [3:0] k;
        start_job(5'd2);
        send(8'd3, 0); send(8'd5, 0); send(8'd4, 0); send(8'd6, 0);
        for (int i = 0; i < 3; i++) recv(0, got[i], held);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        repeat (2) @(negedge clk);
        k = e0[3:0];
        checks++;
        if ({n_clr - c0, n_en - e0, n_done - d0} !== {32'd1, 32'd2, 32'd1}) begin
            fails++;
            $display("FAIL basic_counts clr=%0d en=%0d done=%0d exp 1 2 1", n_clr - c0, n_en - e0, n_done - d0);
        end
        checks++;
        if ({pa[k], pb[k], pa[k + 4'd1], pb[k + 4'd1]} !== {8'd3, 8'd5, 8'd4, 8'd6}) begin
            fails++;
            $display("FAIL basic_operands got=%h/%h %h/%h exp=03/05 04/06", pa[k], pb[k], pa[k + 4'd1], pb[k + 4'd1]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy got=%b exp=0", bus.busy);
        end
    endtask
    task automatic test_max;
        logic [7:0] got [3];
        logic [7:0] exp [3] = '{8'h10, 8'hE0, 8'h0F};
        logic held;
        int e0 = n_en;
        start_job(5'd16);
        for (int i = 0; i < 32; i++) send(8'hFF, 0);
        for (int i = 0; i < 3; i++) recv(0, got[i], held);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL max_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (n_en - e0 !== 16) begin
            fails++;
            $display("FAIL max_en_count got=%0d exp=16", n_en - e0);
        end
    endtask
    task automatic test_backpressure;
        logic [7:0] ops [6] = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
        logic [7:0] got [3];
        logic [7:0] exp [3] = '{8'h90, 8'h1A, 8'h00};
        logic held [3];
        int e0 = n_en;
        start_job(5'd3);
        for (int i = 0; i < 6; i++) send(ops[i], (i % 3) + 1);
        for (int i = 0; i < 3; i++) recv(i == 1 ? 3 : 0, got[i], held[i]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (held[1] !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold got=%b exp=1", held[1]);
        end
        checks++;
        if (n_en - e0 !== 3) begin
            fails++;
            $display("FAIL bp_en_count got=%0d exp=3", n_en - e0);
        end
    endtask
    task automatic test_illegal;
        int r0 = n_err, c0 = n_clr, e0 = n_en;
        start_job(5'd0);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL illegal_len0 err=%b busy=%b exp err=1 busy=0", bus.err, bus.busy);
        end
        start_job(5'd17);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL illegal_len17 err=%b busy=%b exp err=1 busy=0", bus.err, bus.busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({n_err - r0, n_clr - c0, n_en - e0, 31'd0, bus.busy} !== {32'd2, 32'd0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL illegal_counts err=%0d clr=%0d en=%0d busy=%b exp 2 0 0 0", n_err - r0, n_clr - c0, n_en - e0, bus.busy);
        end
    endtask
    task automatic test_reset_mid_job;
        logic [7:0] got [3];
        logic [7:0] exp [3] = '{8'h3F, 8'h00, 8'h00};
        logic held;
        int d0 = n_done;
        start_job(5'd2);
        send(8'd3, 0); send(8'd5, 0); send(8'd4, 0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mac_a !== 8'd4) begin
            fails++;
            $display("FAIL rst_pre_state in_ready=%b mac_a=%h exp 1 04", bus.in_ready, bus.mac_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.in_ready, bus.mac_en, bus.mac_clr, bus.out_valid, bus.done, bus.err, bus.mac_a, bus.mac_b, bus.out_data} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs busy=%b a=%h b=%h required all zero", bus.busy, bus.mac_a, bus.mac_b);
        end
        @(negedge clk);
        rst = 1'b0;
        start_job(5'd1);
        send(8'd7, 0); send(8'd9, 0);
        for (int i = 0; i < 3; i++) recv(0, got[i], held);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL rst_job_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_done - d0 !== 1) begin
            fails++;
            $display("FAIL rst_done_count got=%0d exp=1", n_done - d0);
        end
    endtask
`ifdef MAC_SEQ_ABORT_EN
    task automatic test_abort;
        logic [7:0] got;
        logic held;
        int d0 = n_done;
        start_job(5'd1);
        send(8'd2, 0); send(8'd3, 0);
        recv(0, got, held);
        checks++;
        if (got !== 8'h06) begin
            fails++;
            $display("FAIL abort_byte0 got=%h exp=06", got);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({bus.busy, bus.err, bus.done} !== 3'b010) begin
            fails++;
            $display("FAIL abort_status busy=%b err=%b done=%b exp 0 1 0", bus.busy, bus.err, bus.done);
        end
        start_job(5'd1);
        send(8'd7, 0); send(8'd9, 0);
        recv(0, got, held);
        checks++;
        if (got !== 8'h3F) begin
            fails++;
            $display("FAIL abort_next_job got=%h exp=3F", got);
        end
        recv(0, got, held); recv(0, got, held);
        repeat (2) @(negedge clk);
        checks++;
        if (n_done - d0 !== 1) begin
            fails++;
            $display("FAIL abort_done_count got=%0d exp=1", n_done - d0);
        end
    endtask
`endif
    initial begin
        bus.start = 1'b0;
        bus.cfg_len = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_illegal();
        test_reset_mid_job();
`ifdef MAC_SEQ_ABORT_EN
        test_abort();
`endif
        checks++;
        if (n_viol !== 0) begin
            fails++;
            $display("FAIL ready_exclusive violations=%0d exp=0", n_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the MAC accelerator datapath.
- Accepts a vector length and a byte stream of operand pairs from the host side.
- Issues clear and multiply-accumulate strobes to the external MAC datapath, waits out its latency, then streams the accumulated result back LSB-first as bytes.
- Sits between the tt_um top-level I/O mux and the MAC datapath.

Parameters:
- ACC_W, 20, accumulator width read from the datapath; result bytes = ceil(ACC_W/8).
- LEN_W, 5, width of cfg_len; legal lengths are 1..16.
- MAC_LAT, 1, cycles from the mac_en edge until mac_acc reflects that product (at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset. Asserted when 1; the top level drives it inverted.
- start  in  1  begin a job; sampled only in IDLE.
- cfg_len  in  LEN_W  number of operand pairs; sampled with start.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts an operand this cycle.
- mac_a  out  8  operand A to the datapath.
- mac_b  out  8  operand B to the datapath.
- mac_en  out  1  one-cycle accumulate strobe.
- mac_clr  out  1  one-cycle accumulator clear strobe.
- mac_acc  in  ACC_W  accumulator value from the datapath.
- out_data  out  8  result byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result byte is accepted.
- err  out  1  one-cycle pulse when start is sampled with cfg_len == 0 or > 16.

Behaviour:
- Reset: state = IDLE. All outputs 0, including mac_a, mac_b, the count and the byte index.
- IDLE:
  - start with a legal cfg_len: latch the length, clear the count, go to CLEAR.
  - start with an illegal cfg_len: pulse err next cycle, stay in IDLE, no mac_clr.
- CLEAR: mac_clr = 1 for exactly one cycle, then go to LOAD_A.
- LOAD_A: in_ready = 1. On in_valid & in_ready, register in_data into mac_a and go to LOAD_B.
- LOAD_B: in_ready = 1. On in_valid & in_ready, register in_data into mac_b and go to ISSUE.
- ISSUE: mac_en = 1 for one cycle; count += 1.
  - count == len: go to WAIT.
  - Otherwise: go to LOAD_A.
  - mac_a and mac_b hold their values until the next capture.
- WAIT: stay exactly MAC_LAT cycles, then register mac_acc into the result register and go to OUT.
- OUT: out_valid = 1; out_data = result byte[idx].
  - Byte 0 is bits 7:0. The top byte is zero-extended above ACC_W.
  - out_data must stay stable while out_valid & !out_ready.
  - On acceptance idx advances. After the last byte: idx = 0, state = IDLE, done = 1 for one cycle.
- start outside IDLE is ignored.
- in_valid while in_ready = 0 is ignored; no data is consumed.
- in_ready is never high in the same cycle as mac_en or out_valid.
- Datapath result width and overflow belong to the datapath; the controller only transports ACC_W bits.
- Reset asserted in any state (mid-load, WAIT, mid-output) returns to IDLE asynchronously.
  - No done pulse.
  - Partial results are discarded.

Optional Feature:
- MAC_SEQ_ABORT_EN defined: adds input port abort (1 bit).
  - abort high in any non-IDLE state → next state IDLE, all strobes 0, no done pulse.
  - The cycle after abort, err pulses and done stays 0.
  - abort in IDLE has no effect.
- Undefined: no abort port; a job completes only through reset or normal completion.

Test Plan:
- The bench models a MAC with MAC_LAT = 1: clear on mac_clr, acc += a*b on mac_en.
- Basic job: len = 2, bytes 3, 5, 4, 6 → mac_clr once, mac_en twice (a/b = 3/5, 4/6); out bytes 0x27, 0x00, 0x00; done pulse; busy returns to 0.
- Maximum job: len = 16, all operand bytes 0xFF → acc 0xFE010; out bytes 0x10, 0xE0, 0x0F.
- Backpressure:
  - Input: in_valid gaps of 1–3 cycles produce no extra mac_en.
  - Output: out_ready low 3 cycles on byte 1 → out_data held at the same value, no byte skipped.
- Illegal length: start with cfg_len = 0, then cfg_len = 17 → err pulses twice; busy, mac_clr and mac_en stay 0.
- Reset mid-job: assert rst_n in LOAD_B of pair 2 → all outputs 0 immediately, no done. A new len = 1 job (7, 9) then returns 0x3F, 0x00, 0x00.
- With MAC_SEQ_ABORT_EN: abort during OUT after byte 0 → IDLE, err pulse, no done; the next job runs correctly.
